// File: rtl/avalon_burst_sram.sv
// avalon_burst_sram: on-chip SRAM behind an Avalon-MM slave port.
// Byte-enable writes, linear read/write bursts driven by an internal
// address counter, and an RL-deep read pipeline that raises readdatavalid.
module avalon_burst_sram #(
  parameter int DW  = 32,
  parameter int AW  = 8,
  parameter int RL  = 1,
  parameter int BCW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              read,
  input  logic              write,
  input  logic [DW/8-1:0]   byteenable,
  input  logic [DW-1:0]     writedata,
  input  logic [BCW-1:0]    burstcount,
  output logic              waitrequest,
  output logic [DW-1:0]     readdata,
  output logic              readdatavalid
);

  localparam int BEW = DW / 8;

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [BCW-1:0]          rem_q, rem_d;
  logic [BCW-1:0]          n_beats;
  logic                    wr_en, rd_en;
  logic [AW-1:0]           wr_addr, rd_addr;
  logic [DW-1:0]           mem [2**AW];
  logic [RL-1:0]           vld_pipe_q;
  logic [RL-1:0][DW-1:0]   dat_pipe_q;

  // A burstcount of zero behaves as a single beat.
  assign n_beats = (burstcount == '0) ? BCW'(1) : burstcount;

  // State, burst counter and remaining-beat register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  // Command decode: write wins over read in IDLE; bursts walk the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = address;
    rd_addr = address;
    case (state_q)
      IDLE: begin
        if (write) begin
          wr_en = 1'b1;
          if (n_beats > BCW'(1)) begin
            cnt_d   = AW'(address + 1'b1);
            rem_d   = BCW'(n_beats - 1'b1);
            state_d = WBURST;
          end
        end else if (read) begin
          rd_en = 1'b1;
          if (n_beats > BCW'(1)) begin
            cnt_d   = AW'(address + 1'b1);
            rem_d   = BCW'(n_beats - 1'b1);
            state_d = RBURST;
          end
        end
      end
      RBURST: begin
        rd_en   = 1'b1;
        rd_addr = cnt_q;
        cnt_d   = AW'(cnt_q + 1'b1);
        rem_d   = BCW'(rem_q - 1'b1);
        if (rem_q == BCW'(1)) state_d = IDLE;
      end
      WBURST: begin
        // write low is a stall; nothing advances
        if (write) begin
          wr_en   = 1'b1;
          wr_addr = cnt_q;
          cnt_d   = AW'(cnt_q + 1'b1);
          rem_d   = BCW'(rem_q - 1'b1);
          if (rem_q == BCW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BEW; i++) begin
        if (byteenable[i]) mem[wr_addr][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
  end

  // Read pipeline: sample at issue, shift valid/data; stages hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= rd_en;
      if (rd_en) dat_pipe_q[0] <= mem[rd_addr];
      for (int i = 1; i < RL; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
      end
    end
  end

  assign waitrequest   = (state_q == RBURST);
  assign readdatavalid = vld_pipe_q[RL-1];
  assign readdata      = dat_pipe_q[RL-1];

endmodule

// File: tb/tb_avalon_burst_sram.sv
// Bench for avalon_burst_sram: four instances (RL=1..4) share one stimulus
// stream; a transaction-level model predicts every output every cycle.
module tb_avalon_burst_sram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  burstcount = '0;
  logic [3:0]  wq;
  logic [3:0]  rdv;
  logic [31:0] rd [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    avalon_burst_sram #(.DW(32), .AW(8), .RL(g + 1), .BCW(4)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .read          (read),
      .write         (write),
      .byteenable    (byteenable),
      .writedata     (writedata),
      .burstcount    (burstcount),
      .waitrequest   (wq[g]),
      .readdata      (rd[g]),
      .readdatavalid (rdv[g])
    );
  end

  // Reference model: memory image, outstanding burst beats, issue history.
  logic [31:0] mem_m [256];
  bit          hist_v [4096];
  logic [31:0] hist_d [4096];
  logic [31:0] exp_rd [4];
  int          rd_left, wr_left;
  logic [7:0]  rd_ptr, wr_ptr;
  int          c = 0;
  int          vectors = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit w, input logic [7:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic [3:0] bc);
    read = r; write = w; address = a; byteenable = be; writedata = d; burstcount = bc;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 8'($urandom), 4'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic merge(input logic [7:0] a);
    for (int i = 0; i < 4; i++)
      if (byteenable[i]) mem_m[a][i*8 +: 8] = writedata[i*8 +: 8];
  endtask

  task automatic issue(input logic [7:0] a);
    hist_v[c] = 1'b1;
    hist_d[c] = mem_m[a];
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model by the
  // edge that ends the cycle using the inputs currently driven.
  task automatic tick();
    int nb;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      bit v;
      v = (c >= g + 1) ? hist_v[c-g-1] : 1'b0;
      if (v) exp_rd[g] = hist_d[c-g-1];
      chk($sformatf("rdv_rl%0d_c%0d", g + 1, c), {31'b0, rdv[g]}, {31'b0, v});
      chk($sformatf("rdata_rl%0d_c%0d", g + 1, c), rd[g], exp_rd[g]);
      chk($sformatf("wreq_rl%0d_c%0d", g + 1, c), {31'b0, wq[g]}, {31'b0, rd_left != 0});
    end
    nb = (burstcount == 0) ? 1 : int'(burstcount);
    if (rd_left != 0) begin
      issue(rd_ptr); rd_ptr++; rd_left--;
    end else if (wr_left != 0) begin
      if (write) begin merge(wr_ptr); wr_ptr++; wr_left--; end
    end else if (write) begin
      merge(address); wr_left = nb - 1; wr_ptr = address + 8'd1;
    end else if (read) begin
      issue(address); rd_left = nb - 1; rd_ptr = address + 8'd1;
    end
    @(posedge clk); #1;
    c++;
  endtask

  // Asynchronous reset with random inputs; outputs must clear at once.
  task automatic do_reset();
    reset_n = 1'b0;
    set_in(1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom), $urandom, 4'($urandom));
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_rdv_rl%0d", g + 1), {31'b0, rdv[g]}, 32'd0);
      chk($sformatf("rst_rdata_rl%0d", g + 1), rd[g], 32'd0);
      chk($sformatf("rst_wreq_rl%0d", g + 1), {31'b0, wq[g]}, 32'd0);
      exp_rd[g] = '0;
    end
    for (int i = 0; i < 4096; i++) hist_v[i] = 1'b0;
    rd_left = 0; wr_left = 0;
    @(posedge clk); #1;
    c++;
    reset_n = 1'b1;
    idle();
  endtask

  task automatic wr1(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    set_in(1'b0, 1'b1, a, be, d, 4'd1); tick(); idle();
  endtask

  task automatic rd1(input logic [7:0] a);
    set_in(1'b1, 1'b0, a, 4'($urandom), $urandom, 4'd1); tick(); idle();
  endtask

  initial begin
    int wcnt;
    logic [7:0] a;
    rd_left = 0; wr_left = 0; rd_ptr = '0; wr_ptr = '0;
    for (int g = 0; g < 4; g++) exp_rd[g] = '0;
    #2;
    do_reset();

    // Give every word a known value.
    for (int i = 0; i < 256; i++) wr1(8'(i), $urandom, 4'hF);

    // Byte-enable merge, then read: RL=2 instance shows data two cycles on.
    wr1(8'h10, 32'hDEADBEEF, 4'hF);
    wr1(8'h10, 32'h00000055, 4'h1);
    rd1(8'h10);
    tick();
    chk("be_merge_vld", {31'b0, rdv[1]}, 32'd1);
    chk("be_merge_data", rd[1], 32'hDEADBE55);
    repeat (4) tick();

    // Wrapping read burst of 4 starting at 0xFE.
    wr1(8'hFE, 32'd1, 4'hF);
    wr1(8'hFF, 32'd2, 4'hF);
    wr1(8'h00, 32'd3, 4'hF);
    wr1(8'h01, 32'd4, 4'hF);
    set_in(1'b1, 1'b0, 8'hFE, 4'hF, $urandom, 4'd4); tick();
    set_in(1'b1, 1'b1, 8'h33, 4'hF, $urandom, 4'd2);  // ignored while busy
    wcnt = 0;
    while (wq[0] && wcnt < 10) begin wcnt++; tick(); end
    chk("rburst_wait_cycles", wcnt, 32'd3);
    rd1(8'h10);                                       // no bubble after burst
    repeat (5) tick();

    // Stalled write burst of 3 at 0x20.
    set_in(1'b0, 1'b1, 8'h20, 4'hF, 32'hAAAA0001, 4'd3); tick();
    set_in(1'b1, 1'b1, 8'h77, 4'hF, 32'hBBBB0002, 4'd9); tick();
    set_in(1'b1, 1'b0, 8'h55, 4'hF, $urandom, 4'd5); tick();
    set_in(1'b1, 1'b0, 8'h56, 4'hF, $urandom, 4'd5); tick();
    set_in(1'b0, 1'b1, 8'h99, 4'hF, 32'hCCCC0003, 4'd1); tick();
    idle();
    for (int i = 0; i < 4; i++) rd1(8'h20 + 8'(i));
    repeat (5) tick();

    // Collision: the write lands, the read is dropped.
    set_in(1'b1, 1'b1, 8'h40, 4'hF, 32'h12345678, 4'd1); tick(); idle();
    rd1(8'h40);
    repeat (5) tick();

    // Reset in the middle of an 8-beat read burst.
    set_in(1'b1, 1'b0, 8'h40, 4'hF, $urandom, 4'd8); tick(); idle();
    tick(); tick();
    do_reset();
    rd1(8'h40);
    rd1(8'h20);
    repeat (5) tick();

    // Back-to-back single reads at random addresses.
    for (int i = 0; i < 16; i++) rd1(8'($urandom));
    repeat (5) tick();

    // Fully random traffic, including bursts, stalls and collisions.
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      set_in(1'($urandom), ($urandom_range(0, 2) == 0), a, 4'($urandom), $urandom, 4'($urandom));
      tick();
    end
    idle();
    repeat (24) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
